// File: rtl/usb_rx_pkg.sv
// Shared types and constants for the USB full-speed DP/DM receive decoder.
package usb_rx_pkg;

    typedef enum logic [1:0] {
        LS_SE0 = 2'b00,
        LS_K   = 2'b01,
        LS_J   = 2'b10,
        LS_SE1 = 2'b11
    } line_state_t;

    typedef enum logic [2:0] {
        IDLE,
        DATA,
        EOP1,
        EOP2,
        RECOVER
    } rx_state_t;

    // K,J,K,J,K,J,K,K with the oldest line state in the top two bits.
    localparam logic [15:0] SYNC_PATTERN = 16'b01_10_01_10_01_10_01_01;
    localparam logic [15:0] SHREG_IDLE   = {8{2'b10}};

    localparam int MAX_PKT_BITS_DEFAULT = 600;

endpackage

// File: rtl/nrzi_unstuff.sv
// NRZI decoder with bit-unstuffing: tracks runs of 1s and flags the bit after six of them.
module nrzi_unstuff
    import usb_rx_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  line_state_t line_i,
    input  line_state_t prev_i,
    input  logic        decode_i,
    input  logic        clear_i,
    output logic        bit_o,
    output logic        bit_valid_o,
    output logic        stuff_err_o
);

    logic [2:0] ones_q, ones_d;

    assign bit_o = (line_i == prev_i);

    // After six 1s the next bit must be a stuffed 0 (dropped); a 1 there is a stuffing violation.
    always_comb begin
        ones_d      = ones_q;
        bit_valid_o = 1'b0;
        stuff_err_o = 1'b0;
        if (clear_i) begin
            ones_d = '0;
        end else if (decode_i) begin
            if (ones_q == 3'd6) begin
                ones_d      = '0;
                stuff_err_o = bit_o;
            end else begin
                bit_valid_o = 1'b1;
                ones_d      = bit_o ? ones_q + 3'd1 : 3'd0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ones_q <= '0;
        end else begin
            ones_q <= ones_d;
        end
    end

endmodule

// File: rtl/dpdm_rx_decoder.sv
// USB DP/DM receive decoder: SYNC hunt, NRZI/unstuff, EOP detection and error recovery.
module dpdm_rx_decoder
    import usb_rx_pkg::*;
#(
    parameter int MAX_PKT_BITS = MAX_PKT_BITS_DEFAULT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] host_in,
    input  logic       rx_enable,
    output logic       s_out,
    output logic       bit_valid,
    output logic       pkt_start,
    output logic       eop,
    output logic       rx_err
);

    rx_state_t   state_q, state_d;
    line_state_t line_q, prev_q;
    logic [15:0] shreg_q, shreg_d;
    logic [9:0]  bit_cnt_q, bit_cnt_d;
    logic        s_out_q, bit_valid_q, pkt_start_q, eop_q, rx_err_q;
    logic        s_out_d, bit_valid_d, pkt_start_d, eop_d, rx_err_d;
    logic        sync_hit, decode_en, ones_clear;
    logic        nrzi_bit, nrzi_valid, stuff_err;

    // The shift register's incoming value is matched so pkt_start keeps the same latency as data.
    assign sync_hit   = ({shreg_q[13:0], line_q} == SYNC_PATTERN);
    assign decode_en  = rx_enable && (state_q == DATA) && ((line_q == LS_J) || (line_q == LS_K));
    assign ones_clear = !rx_enable || ((state_q == IDLE) && sync_hit);

    nrzi_unstuff u_nrzi_unstuff (
        .clk         (clk),
        .rst         (rst),
        .line_i      (line_q),
        .prev_i      (prev_q),
        .decode_i    (decode_en),
        .clear_i     (ones_clear),
        .bit_o       (nrzi_bit),
        .bit_valid_o (nrzi_valid),
        .stuff_err_o (stuff_err)
    );

    always_comb begin
        state_d     = state_q;
        shreg_d     = {shreg_q[13:0], line_q};
        bit_cnt_d   = bit_cnt_q;
        s_out_d     = 1'b0;
        bit_valid_d = 1'b0;
        pkt_start_d = 1'b0;
        eop_d       = 1'b0;
        rx_err_d    = 1'b0;
        if (!rx_enable) begin
            state_d = IDLE;
            shreg_d = SHREG_IDLE;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (sync_hit) begin
                        pkt_start_d = 1'b1;
                        bit_cnt_d   = '0;
                        shreg_d     = SHREG_IDLE;
                        state_d     = DATA;
                    end
                end
                DATA: begin
                    unique case (line_q)
                        LS_J, LS_K: begin
                            if (stuff_err) begin
                                rx_err_d = 1'b1;
                                state_d  = RECOVER;
                            end else if (nrzi_valid) begin
                                // A further bit once MAX_PKT_BITS have been delivered aborts the packet.
                                if (bit_cnt_q == 10'(MAX_PKT_BITS)) begin
                                    rx_err_d = 1'b1;
                                    state_d  = RECOVER;
                                end else begin
                                    s_out_d     = nrzi_bit;
                                    bit_valid_d = 1'b1;
                                    bit_cnt_d   = bit_cnt_q + 10'd1;
                                end
                            end
                        end
                        LS_SE0: state_d = EOP1;
                        LS_SE1: begin
                            rx_err_d = 1'b1;
                            state_d  = RECOVER;
                        end
                    endcase
                end
                EOP1: begin
                    if (line_q == LS_SE0) begin
                        state_d = EOP2;
                    end else begin
                        rx_err_d = 1'b1;
                        state_d  = RECOVER;
                    end
                end
                EOP2: begin
                    if (line_q == LS_J) begin
                        eop_d   = 1'b1;
                        state_d = IDLE;
                    end else begin
                        rx_err_d = 1'b1;
                        state_d  = RECOVER;
                    end
                end
                RECOVER: begin
                    if ((line_q == LS_J) && (prev_q == LS_J)) begin
                        shreg_d = SHREG_IDLE;
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            line_q      <= LS_J;
            prev_q      <= LS_J;
            shreg_q     <= SHREG_IDLE;
            bit_cnt_q   <= '0;
            s_out_q     <= 1'b0;
            bit_valid_q <= 1'b0;
            pkt_start_q <= 1'b0;
            eop_q       <= 1'b0;
            rx_err_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            line_q      <= line_state_t'(host_in);
            prev_q      <= line_q;
            shreg_q     <= shreg_d;
            bit_cnt_q   <= bit_cnt_d;
            s_out_q     <= s_out_d;
            bit_valid_q <= bit_valid_d;
            pkt_start_q <= pkt_start_d;
            eop_q       <= eop_d;
            rx_err_q    <= rx_err_d;
        end
    end

    assign s_out     = s_out_q;
    assign bit_valid = bit_valid_q;
    assign pkt_start = pkt_start_q;
    assign eop       = eop_q;
    assign rx_err    = rx_err_q;

endmodule

// File: tb/tb_dpdm_rx_decoder.sv
// Bench for dpdm_rx_decoder: packets are NRZI-encoded and bit-stuffed here, and the
// decoded stream is compared with the original payload.
module tb_dpdm_rx_decoder;

    localparam int         TB_MAX = 64;
    localparam logic [1:0] J   = 2'b10;
    localparam logic [1:0] K   = 2'b01;
    localparam logic [1:0] SE0 = 2'b00;
    localparam logic [1:0] SE1 = 2'b11;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] host_in;
    logic       rx_enable;
    logic       s_out, bit_valid, pkt_start, eop, rx_err;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    bit         txBits[$];
    bit         expBits[$];
    bit         bitQ[$];
    logic [1:0] txLine[$];
    int pktCount, eopCount, errCount, zeroViol;
    int lastPktCyc, firstBitCyc, lastEopCyc;
    int syncEndCyc, firstDataCyc, eopDriveCyc;

    dpdm_rx_decoder #(.MAX_PKT_BITS(TB_MAX)) dut (
        .clk       (clk),
        .rst       (rst),
        .host_in   (host_in),
        .rx_enable (rx_enable),
        .s_out     (s_out),
        .bit_valid (bit_valid),
        .pkt_start (pkt_start),
        .eop       (eop),
        .rx_err    (rx_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc = cyc + 1;

    // Collect everything the decoder reports, half a cycle after it changes.
    always @(negedge clk) begin
        if (!rst) begin
            if (bit_valid) begin
                bitQ.push_back(s_out);
                if (firstBitCyc < 0) firstBitCyc = cyc;
            end
            if (!bit_valid && s_out) zeroViol++;
            if (pkt_start) begin pktCount++; lastPktCyc = cyc; end
            if (eop) begin eopCount++; lastEopCyc = cyc; end
            if (rx_err) errCount++;
        end
    end

    task automatic checkOutput(input string tag, input int observed, input int expected);
        checks++;
        if (observed != expected) begin
            errors++;
            $display("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [1:0] s);
        @(posedge clk);
        #1 host_in = s;
    endtask

    task automatic clearMonitor();
        bitQ.delete();
        pktCount = 0; eopCount = 0; errCount = 0;
        lastPktCyc = -1; firstBitCyc = -1; lastEopCyc = -1;
    endtask

    task automatic sendIdle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(J);
    endtask

    task automatic sendSync();
        logic [1:0] pat[8];
        pat = '{K, J, K, J, K, J, K, K};
        for (int i = 0; i < 8; i++) applyStimulus(pat[i]);
        syncEndCyc = cyc;
    endtask

    // NRZI: a 0 toggles the line, a 1 holds it; a 0 is stuffed after every six 1s.
    task automatic encodeBits();
        logic [1:0] lvl;
        int ones;
        txLine.delete();
        lvl  = K;
        ones = 0;
        foreach (txBits[i]) begin
            if (txBits[i]) ones++;
            else begin lvl = ~lvl; ones = 0; end
            txLine.push_back(lvl);
            if (ones == 6) begin
                lvl = ~lvl;
                txLine.push_back(lvl);
                ones = 0;
            end
        end
    endtask

    task automatic sendLines();
        foreach (txLine[i]) begin
            applyStimulus(txLine[i]);
            if (i == 0) firstDataCyc = cyc;
        end
    endtask

    task automatic sendEop();
        applyStimulus(SE0);
        applyStimulus(SE0);
        applyStimulus(J);
        eopDriveCyc = cyc;
        sendIdle(4);
    endtask

    task automatic randomBits(input int n);
        txBits.delete();
        for (int i = 0; i < n; i++) txBits.push_back($urandom_range(0, 3) != 0);
    endtask

    task automatic checkPacket(input string tag, input int expPkt, input int expEop, input int expErr);
        checkOutput({tag, "_pkt_start"}, pktCount, expPkt);
        checkOutput({tag, "_eop"}, eopCount, expEop);
        checkOutput({tag, "_rx_err"}, errCount, expErr);
        checkOutput({tag, "_nbits"}, bitQ.size(), expBits.size());
        for (int i = 0; i < expBits.size() && i < bitQ.size(); i++)
            checkOutput($sformatf("%s_bit%0d", tag, i), int'(bitQ[i]), int'(expBits[i]));
    endtask

    initial begin
        rst = 1'b1; host_in = J; rx_enable = 1'b1; zeroViol = 0;
        clearMonitor();
        repeat (3) @(posedge clk);
        #1 checkOutput("reset_outputs", int'({s_out, bit_valid, pkt_start, eop, rx_err}), 0);
        rst = 1'b0;

        clearMonitor(); sendIdle(4); sendSync();
        txBits = '{1, 0, 0, 1, 0, 1, 1, 0}; expBits = txBits;
        encodeBits(); sendLines(); sendEop();
        checkPacket("pid69", 1, 1, 0);
        checkOutput("lat_pkt_start", lastPktCyc, syncEndCyc + 2);
        checkOutput("lat_first_bit", firstBitCyc, firstDataCyc + 2);
        checkOutput("lat_eop", lastEopCyc, eopDriveCyc + 2);

        clearMonitor(); sendIdle(2); sendSync();
        txBits = '{1, 1, 1, 1, 1, 1, 1}; expBits = txBits;
        encodeBits(); sendLines(); sendEop();
        checkPacket("stuff_drop", 1, 1, 0);

        clearMonitor(); sendIdle(2); sendSync();
        repeat (7) applyStimulus(K);
        sendEop();
        expBits = '{1, 1, 1, 1, 1, 1};
        checkPacket("stuff_err", 1, 0, 1);

        clearMonitor(); sendIdle(2); sendSync();
        randomBits(20); expBits = txBits;
        encodeBits(); sendLines(); sendEop();
        checkPacket("after_err", 1, 1, 0);

        clearMonitor(); sendIdle(2); sendSync();
        txBits = '{1, 0, 1}; expBits = txBits;
        encodeBits(); sendLines();
        applyStimulus(SE0); applyStimulus(K); sendIdle(4);
        checkPacket("se0_k", 1, 0, 1);

        clearMonitor(); sendIdle(2); sendSync();
        txBits = '{0, 1}; expBits = txBits;
        encodeBits(); sendLines();
        applyStimulus(SE1); sendEop();
        checkPacket("se1_data", 1, 0, 1);

        clearMonitor(); sendIdle(2); sendSync();
        randomBits(TB_MAX); expBits = txBits;
        encodeBits(); sendLines(); sendEop();
        checkPacket("len_max", 1, 1, 0);

        clearMonitor(); sendIdle(2); sendSync();
        randomBits(TB_MAX + 1); expBits = txBits;
        void'(expBits.pop_back());
        encodeBits(); sendLines(); sendEop();
        checkPacket("len_over", 1, 0, 1);

        clearMonitor(); sendIdle(2); sendSync();
        txBits = '{1, 0, 0, 1, 0, 1, 1, 0}; encodeBits();
        for (int i = 0; i < 6; i++) applyStimulus(txLine[i]);
        @(negedge clk);
        #1 rst = 1'b1;
        #1 checkOutput("rst_async_outputs", int'({s_out, bit_valid, pkt_start, eop, rx_err}), 0);
        @(posedge clk);
        #1 rst = 1'b0;
        for (int i = 6; i < 8; i++) applyStimulus(txLine[i]);
        sendEop();
        expBits = '{1, 0, 0, 1};
        checkPacket("rst_mid", 1, 0, 0);

        clearMonitor(); rx_enable = 1'b0; sendIdle(2); sendSync();
        randomBits(16); expBits.delete();
        encodeBits(); sendLines(); sendEop();
        checkPacket("rx_disabled", 0, 0, 0);
        rx_enable = 1'b1;

        for (int p = 0; p < 12; p++) begin
            clearMonitor(); sendIdle($urandom_range(2, 6)); sendSync();
            randomBits($urandom_range(1, TB_MAX)); expBits = txBits;
            encodeBits(); sendLines(); sendEop();
            checkPacket($sformatf("rand%0d", p), 1, 1, 0);
        end

        checkOutput("s_out_zero_when_idle", zeroViol, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
